inst_fetch: RTL and testbench

- Instruction-fetch stage directly downstream of the PC register.
- Takes each new PC and issues a word read to instruction memory over a req/gnt/rvalid handshake.
- Holds the returned instruction until the decode stage accepts it.
- Back-pressures the PC register via fetch_stall; discards in-flight fetches on a branch/jump redirect (flush).

---
 rtl/ifetch_pkg.sv | 16 +
 rtl/ifetch_timeout_cnt.sv | 34 +++
 rtl/inst_fetch.sv | 161 ++++++++++++++++
 tb/tb_inst_fetch.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// the NOP word substituted on a fetch timeout, and default timeout sizing.
package ifetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

   localparam logic [31:0] NOP_INST           = 32'h0000_0000;
   localparam int          DEF_TIMEOUT_CYCLES = 16;
   localparam int          DEF_CNT_W          = 5;

endpackage

// File: rtl/ifetch_timeout_cnt.sv
// Counts WAIT cycles without read data and flags when the fetch has waited
// TIMEOUT_CYCLES cycles. CNT_W must satisfy 2**CNT_W > TIMEOUT_CYCLES.
module ifetch_timeout_cnt
   import ifetch_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CNT_W          = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_inc,
   output logic o_expired
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Expires during the TIMEOUT_CYCLES-th empty WAIT cycle, so the stage
   // leaves WAIT on that cycle's closing edge.
   assign o_expired = i_inc & (r_cnt >= LAST_CNT);

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: issues one word read per accepted PC over a
// req/gnt/rvalid bus and holds the instruction until decode takes it.
// Optional fetch timeout is enabled by defining IFETCH_TIMEOUT_EN.
module inst_fetch
   import ifetch_pkg::*;
`ifdef IFETCH_TIMEOUT_EN
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CNT_W          = DEF_CNT_W
)
`endif
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   input  logic        pc_valid,
   output logic        fetch_stall,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic        fetch_err
);

   fetch_state_t r_state;
   fetch_state_t w_stateNext;
   logic         r_drop;
   logic         w_dropNext;
   logic [31:0]  r_addr;
   logic [31:0]  r_pc;
   logic [31:0]  r_inst;
   logic [31:0]  r_instPc;
   logic         w_accept;
   logic         w_loadData;
   logic         w_loadNop;
   logic         w_timeout;

`ifdef IFETCH_TIMEOUT_EN
   logic r_err;

   ifetch_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_timeoutCnt (
      .clk       (clk),
      .rst       (rst),
      .i_clear   ((r_state == REQ) & imem_gnt),
      .i_inc     ((r_state == WAIT) & ~imem_rvalid),
      .o_expired (w_timeout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_loadNop) begin
         r_err <= 1'b1;
      end else if (w_loadData || (w_stateNext != HOLD)) begin
         r_err <= 1'b0;
      end
   end

   assign fetch_err = r_err;
`else
   assign w_timeout = 1'b0;
   assign fetch_err = 1'b0;
`endif

   // Flush outranks every other transition; a pending drop blocks new
   // requests until the orphaned response has been absorbed.
   always_comb begin
      w_stateNext = r_state;
      w_dropNext  = r_drop;
      w_loadData  = 1'b0;
      w_loadNop   = 1'b0;
      w_accept    = pc_valid & ~flush & ~r_drop &
                    ((r_state == IDLE) | ((r_state == HOLD) & inst_ready));
      case (r_state)
         IDLE: begin
            if (imem_rvalid) w_dropNext = 1'b0;
            if (w_accept)    w_stateNext = REQ;
         end
         REQ: begin
            if (imem_gnt) begin
               w_stateNext = WAIT;
               w_dropNext  = flush;
            end else if (flush) begin
               w_stateNext = IDLE;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               if (r_drop || flush) begin
                  w_stateNext = IDLE;
                  w_dropNext  = 1'b0;
               end else begin
                  w_stateNext = HOLD;
                  w_loadData  = 1'b1;
               end
            end else if (flush) begin
               w_dropNext = 1'b1;
            end else if (w_timeout) begin
               if (r_drop) begin
                  w_stateNext = IDLE;
               end else begin
                  w_stateNext = HOLD;
                  w_loadNop   = 1'b1;
                  w_dropNext  = 1'b1;
               end
            end
         end
         HOLD: begin
            if (imem_rvalid) w_dropNext = 1'b0;
            if (flush) begin
               w_stateNext = IDLE;
            end else if (inst_ready) begin
               w_stateNext = w_accept ? REQ : IDLE;
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_drop   <= 1'b0;
         r_addr   <= '0;
         r_pc     <= '0;
         r_inst   <= '0;
         r_instPc <= '0;
      end else begin
         r_state <= w_stateNext;
         r_drop  <= w_dropNext;
         if (w_accept) begin
            r_addr <= {pc_in[31:2], 2'b00};
            r_pc   <= pc_in;
         end
         if (w_loadData) begin
            r_inst   <= imem_rdata;
            r_instPc <= r_pc;
         end else if (w_loadNop) begin
            r_inst   <= NOP_INST;
            r_instPc <= r_pc;
         end
      end
   end

   assign imem_req    = (r_state == REQ);
   assign imem_addr   = r_addr;
   assign inst_valid  = (r_state == HOLD);
   assign inst        = r_inst;
   assign inst_pc     = r_instPc;
   assign fetch_stall = pc_valid & ~w_accept;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed protocol scenarios followed by a random
// phase checked against a transaction-level model of the fetch pipeline.
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in;
   logic        pc_valid;
   logic        fetch_stall;
   logic        flush;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic        fetch_err;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

`ifdef IFETCH_TIMEOUT_EN
   inst_fetch #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
`else
   inst_fetch dut (
`endif
      .clk         (clk),
      .rst         (rst),
      .pc_in       (pc_in),
      .pc_valid    (pc_valid),
      .fetch_stall (fetch_stall),
      .flush       (flush),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .fetch_err   (fetch_err)
   );

   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return (addr * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
   endfunction

   function automatic logic [31:0] alignWord(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkBit(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic pv, input logic [31:0] pc, input logic rdy,
                                input logic fl, input logic gnt, input logic rv,
                                input logic [31:0] rd);
      pc_valid    = pv;
      pc_in       = pc;
      inst_ready  = rdy;
      flush       = fl;
      imem_gnt    = gnt;
      imem_rvalid = rv;
      imem_rdata  = rd;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Complete fetch from IDLE with single-cycle gnt and rvalid, then retire it.
   task automatic doFetch(input logic [31:0] pc, input logic [31:0] data, input string tag);
      applyStimulus(1'b1, pc, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick;
      checkBit({tag, "_req"}, imem_req, 1'b1);
      checkOutput({tag, "_addr"}, imem_addr, alignWord(pc));
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      tick;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, data);
      tick;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checkBit({tag, "_valid"}, inst_valid, 1'b1);
      checkOutput({tag, "_inst"}, inst, data);
      checkOutput({tag, "_pc"}, inst_pc, pc);
      inst_ready = 1'b1;
      tick;
      inst_ready = 1'b0;
      checkBit({tag, "_retired"}, inst_valid, 1'b0);
   endtask

   // Transaction model state for the random phase.
   logic [31:0] pcQ[$];
   logic [31:0] nextPc;
   logic        reqPending;
   logic        waiting;
   int          waitCnt;
   logic        haveData;

   initial begin
      logic        pv, rdy, gnt, rv, expAccept;
      logic [31:0] rd;
      int          n;

      rst = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      #12;
      checkBit("rst_req", imem_req, 1'b0);
      checkOutput("rst_addr", imem_addr, 32'h0);
      checkOutput("rst_inst", inst, 32'h0);
      checkOutput("rst_instpc", inst_pc, 32'h0);
      checkBit("rst_valid", inst_valid, 1'b0);
      checkBit("rst_err", fetch_err, 1'b0);
      checkBit("rst_stall", fetch_stall, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // First fetch at minimum latency, then a held instruction and a back-to-back accept.
      applyStimulus(1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      #1 checkBit("first_nostall", fetch_stall, 1'b0);
      tick;
      checkBit("first_req", imem_req, 1'b1);
      checkOutput("first_addr", imem_addr, 32'h0000_0040);
      applyStimulus(1'b1, 32'h0000_0044, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      #1 checkBit("req_stall", fetch_stall, 1'b1);
      tick;
      checkBit("wait_req", imem_req, 1'b0);
      checkBit("wait_valid", inst_valid, 1'b0);
      applyStimulus(1'b1, 32'h0000_0044, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2402_0005);
      #1 checkBit("wait_stall", fetch_stall, 1'b1);
      tick;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hFFFF_FFFF;
      checkBit("first_valid", inst_valid, 1'b1);
      checkOutput("first_inst", inst, 32'h2402_0005);
      checkOutput("first_instpc", inst_pc, 32'h0000_0040);
      for (int i = 0; i < 4; i++) begin
         #1 checkBit("hold_stall", fetch_stall, 1'b1);
         tick;
         checkBit("hold_valid", inst_valid, 1'b1);
         checkOutput("hold_inst", inst, 32'h2402_0005);
      end
      inst_ready = 1'b1;
      #1 checkBit("b2b_nostall", fetch_stall, 1'b0);
      tick;
      checkBit("b2b_req", imem_req, 1'b1);
      checkOutput("b2b_addr", imem_addr, 32'h0000_0044);
      checkBit("b2b_valid", inst_valid, 1'b0);

      // Flush while waiting for data: the late response must be discarded.
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      tick;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      tick;
      flush = 1'b0;
      tick;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
      tick;
      imem_rvalid = 1'b0;
      checkBit("flushw_valid", inst_valid, 1'b0);
      checkBit("flushw_req", imem_req, 1'b0);
      tick;
      checkBit("flushw_valid2", inst_valid, 1'b0);
      doFetch(32'h0000_0100, 32'h1111_2222, "after_flush");
      doFetch(32'h0000_0046, 32'h3333_4444, "unaligned");

      // Flush in REQ without and with a same-cycle grant.
      applyStimulus(1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      tick;
      flush = 1'b0;
      checkBit("flushr_req", imem_req, 1'b0);
      applyStimulus(1'b1, 32'h0000_0304, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      tick;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hBAD0_BAD0);
      tick;
      imem_rvalid = 1'b0;
      checkBit("flushg_valid", inst_valid, 1'b0);
      tick;
      checkBit("flushg_valid2", inst_valid, 1'b0);
      doFetch(32'h0000_0308, 32'h5555_6666, "after_flushg");

      // Flush while holding an instruction.
      applyStimulus(1'b1, 32'h0000_0400, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      tick;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h7777_0000);
      tick;
      checkBit("flushh_pre", inst_valid, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      tick;
      flush = 1'b0;
      checkBit("flushh_valid", inst_valid, 1'b0);
      checkBit("flushh_req", imem_req, 1'b0);

      // Reset mid-fetch, then a stray rvalid after release.
      applyStimulus(1'b1, 32'h0000_0500, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      tick;
      imem_gnt = 1'b0;
      #2 rst = 1'b1;
      #1;
      checkBit("midrst_req", imem_req, 1'b0);
      checkOutput("midrst_addr", imem_addr, 32'h0);
      checkOutput("midrst_inst", inst, 32'h0);
      checkOutput("midrst_instpc", inst_pc, 32'h0);
      checkBit("midrst_valid", inst_valid, 1'b0);
      #1 rst = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFEED_F00D);
      tick;
      imem_rvalid = 1'b0;
      checkBit("late_rv_valid", inst_valid, 1'b0);
      checkBit("late_rv_req", imem_req, 1'b0);
      tick;
      checkBit("late_rv_valid2", inst_valid, 1'b0);

`ifdef IFETCH_TIMEOUT_EN
      // Timeout: no rvalid, NOP with error after four empty WAIT cycles.
      applyStimulus(1'b1, 32'h0000_0600, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      tick;
      imem_gnt = 1'b0;
      n = 0;
      while (!inst_valid && n < 20) begin
         tick;
         n++;
      end
      checkOutput("to_cycles", 32'(n), 32'd4);
      checkBit("to_valid", inst_valid, 1'b1);
      checkOutput("to_inst", inst, 32'h0);
      checkOutput("to_instpc", inst_pc, 32'h0000_0600);
      checkBit("to_err", fetch_err, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h7777_7777);
      tick;
      imem_rvalid = 1'b0;
      checkOutput("to_late_inst", inst, 32'h0);
      checkBit("to_late_err", fetch_err, 1'b1);
      inst_ready = 1'b1;
      tick;
      inst_ready = 1'b0;
      checkBit("to_retired", inst_valid, 1'b0);
      checkBit("to_err_clr", fetch_err, 1'b0);
      doFetch(32'h0000_0604, 32'h8888_9999, "after_to");
`endif

      // Random phase: random grant/data latency, back-pressure and PC flow.
      reqPending = 1'b0;
      waiting    = 1'b0;
      waitCnt    = 0;
      haveData   = 1'b0;
      nextPc     = $urandom;
      for (int cyc = 0; cyc < 600; cyc++) begin
         checkBit("rnd_req", imem_req, reqPending);
         if (reqPending) checkOutput("rnd_addr", imem_addr, alignWord(pcQ[0]));
         checkBit("rnd_valid", inst_valid, haveData);
         if (haveData) begin
            checkOutput("rnd_inst", inst, memWord(alignWord(pcQ[0])));
            checkOutput("rnd_instpc", inst_pc, pcQ[0]);
         end
         checkBit("rnd_err", fetch_err, 1'b0);

         gnt = reqPending && ($urandom_range(0, 2) != 0);
         rv  = waiting && (waitCnt == 0);
         rd  = rv ? memWord(alignWord(pcQ[0])) : $urandom;
         if (!waiting && ($urandom_range(0, 7) == 0)) rv = 1'b1;
         pv  = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 1) != 0);
         applyStimulus(pv, nextPc, rdy, 1'b0, gnt, rv, rd);

         expAccept = pv && ((!reqPending && !waiting && !haveData) || (haveData && rdy));
         #1 checkBit("rnd_stall", fetch_stall, pv && !expAccept);
         @(posedge clk);
         #1;

         if (haveData && rdy) begin
            void'(pcQ.pop_front());
            haveData = 1'b0;
         end
         if (waiting && rv) begin
            haveData = 1'b1;
            waiting  = 1'b0;
         end else if (waiting && waitCnt > 0) begin
            waitCnt--;
         end
         if (gnt) begin
            reqPending = 1'b0;
            waiting    = 1'b1;
            waitCnt    = $urandom_range(0, 2);
         end
         if (expAccept) begin
            pcQ.push_back(nextPc);
            reqPending = 1'b1;
            nextPc     = $urandom;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
